// File: rtl/pipe_alu.sv
// pipe_alu: elastic N-stage ALU pipeline (add/sub/and/or) with valid/ready
// on both sides, bubble collapsing, back-pressure and synchronous flush.
//   clk, rst (async, active-low)
//   valid_i/ready_o/sel_i/op1_i/op2_i : upstream side
//   valid_o/ready_i/res_o/zero_o/neg_o : downstream side
//   flush_i : kill in-flight work, count_o : occupancy
module pipe_alu #(
  parameter int DWIDTH = 32,
  parameter int STAGES = 3,
  localparam int CW = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        sel_i,
  input  logic [DWIDTH-1:0] op1_i,
  input  logic [DWIDTH-1:0] op2_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              zero_o,
  output logic              neg_o,
  output logic [CW-1:0]     count_o
);

  typedef struct packed {
    logic [1:0]        sel;
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
  } op_t;

  typedef struct packed {
    logic [DWIDTH-1:0] res;
    logic              zero;
    logic              neg;
  } res_t;

  logic [STAGES-1:0]  v_q, v_d;
  logic [STAGES-1:0]  adv;
  op_t                op_q, op_d;
  res_t [STAGES-1:1]  pl_q, pl_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DWIDTH-1:0]  alu_r;
  res_t               alu;
  logic               in_xfer;
  logic               out_xfer;

  // A stage may advance if downstream is ready or any stage
  // at or after it is empty (a bubble absorbs the shift).
  always_comb begin
    adv = '0;
    for (int s = 0; s < STAGES; s++) begin
      adv[s] = ready_i;
      for (int j = s; j < STAGES; j++)
        if (!v_q[j]) adv[s] = 1'b1;
    end
  end

  assign ready_o  = adv[0] && !flush_i && rst;
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = v_q[STAGES-1] && ready_i;

  always_comb begin
    alu_r = '0;
    unique case (op_q.sel)
      2'b00: alu_r = op_q.a + op_q.b;
      2'b01: alu_r = op_q.a - op_q.b;
      2'b10: alu_r = op_q.a & op_q.b;
      2'b11: alu_r = op_q.a | op_q.b;
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    alu      = '0;
    alu.res  = alu_r;
    alu.zero = (alu_r == '0);
    alu.neg  = alu_r[DWIDTH-1];
  end

  always_comb begin
    v_d  = v_q;
    op_d = op_q;
    pl_d = pl_q;
    if (adv[0]) begin
      v_d[0]   = in_xfer;
      op_d.sel = sel_i;
      op_d.a   = op1_i;
      op_d.b   = op2_i;
    end
    if (adv[1]) begin
      v_d[1]  = v_q[0];
      pl_d[1] = alu;
    end
    for (int s = 2; s < STAGES; s++) begin
      if (adv[s]) begin
        v_d[s]  = v_q[s-1];
        pl_d[s] = pl_q[s-1];
      end
    end
    if (flush_i) v_d = '0;
  end

  always_comb begin
    cnt_d = cnt_q + CW'(in_xfer) - CW'(out_xfer);
    if (flush_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q   <= '0;
      op_q  <= '0;
      pl_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      op_q  <= op_d;
      pl_q  <= pl_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_o = v_q[STAGES-1];
  assign res_o   = pl_q[STAGES-1].res;
  assign zero_o  = pl_q[STAGES-1].zero;
  assign neg_o   = pl_q[STAGES-1].neg;
  assign count_o = cnt_q;

endmodule

// File: tb/tb_pipe_alu.sv
// tb_pipe_alu: directed checks of pipe_alu, 32-bit/3-stage and
// 8-bit/5-stage instances.
module tb_pipe_alu;

  logic        clk;
  logic        rst;
  logic        valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [1:0]  sel_i;
  logic [31:0] op1_i, op2_i, res_o;
  logic        zero_o, neg_o;
  logic [1:0]  count_o;

  logic        vb_i, rb_o, fb_i, vb_o, rb_i;
  logic [1:0]  sb_i;
  logic [7:0]  ab_i, bb_i, resb_o;
  logic        zb_o, nb_o;
  logic [2:0]  cb_o;

  int errors = 0;
  int checks = 0;

  pipe_alu #(.DWIDTH(32), .STAGES(3)) dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .ready_o(ready_o),
    .sel_i(sel_i), .op1_i(op1_i), .op2_i(op2_i),
    .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .res_o(res_o), .zero_o(zero_o), .neg_o(neg_o),
    .count_o(count_o)
  );

  pipe_alu #(.DWIDTH(8), .STAGES(5)) dutb (
    .clk(clk), .rst(rst),
    .valid_i(vb_i), .ready_o(rb_o),
    .sel_i(sb_i), .op1_i(ab_i), .op2_i(bb_i),
    .flush_i(fb_i),
    .valid_o(vb_o), .ready_i(rb_i),
    .res_o(resb_o), .zero_o(zb_o), .neg_o(nb_o),
    .count_o(cb_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] s,
                      input logic [31:0] a,
                      input logic [31:0] b);
    valid_i = 1'b1;
    sel_i   = s;
    op1_i   = a;
    op2_i   = b;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    sel_i   = 2'b00;
    op1_i   = '0;
    op2_i   = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    flush_i = 1'b0;
    ready_i = 1'b1;
    vb_i = 1'b0; sb_i = 2'b00; ab_i = '0; bb_i = '0;
    fb_i = 1'b0; rb_i = 1'b1;
    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_res",   64'(res_o),   64'd0);
    chk("rst_zero",  64'(zero_o),  64'd0);
    chk("rst_cnt",   64'(count_o), 64'd0);
    chk("rst_rdy",   64'(ready_o), 64'd0);
    rst = 1'b1;
    #1;
    chk("rel_rdy", 64'(ready_o), 64'd1);

    // streaming, ready_i=1
    send(2'b00, 32'd5, 32'd7);
    tick();
    chk("st_v0",   64'(valid_o), 64'd0);
    chk("st_cnt1", 64'(count_o), 64'd1);
    send(2'b01, 32'd3, 32'd5);
    tick();
    chk("st_v1",   64'(valid_o), 64'd0);
    send(2'b10, 32'h0000F0F0, 32'h00000FF0);
    tick();
    chk("st_lat3", 64'(valid_o), 64'd1);
    chk("st_add",  64'(res_o),   64'd12);
    chk("st_cnt3", 64'(count_o), 64'd3);
    send(2'b11, 32'd0, 32'd0);
    tick();
    chk("st_sub",  64'(res_o),   64'hFFFFFFFE);
    chk("st_neg",  64'(neg_o),   64'd1);
    chk("st_cntk", 64'(count_o), 64'd3);
    idle();
    tick();
    chk("st_and",  64'(res_o),   64'h000000F0);
    chk("st_vand", 64'(valid_o), 64'd1);
    tick();
    chk("st_or",   64'(res_o),   64'd0);
    chk("st_zero", 64'(zero_o),  64'd1);
    chk("st_vor",  64'(valid_o), 64'd1);
    tick();
    chk("st_done", 64'(valid_o), 64'd0);
    chk("st_cnt0", 64'(count_o), 64'd0);

    // back-pressure: five adds i + 10*i = 11*i
    ready_i = 1'b0;
    send(2'b00, 32'd1, 32'd10);
    tick();
    send(2'b00, 32'd2, 32'd20);
    tick();
    send(2'b00, 32'd3, 32'd30);
    tick();
    chk("bp_cnt3", 64'(count_o), 64'd3);
    chk("bp_rdy0", 64'(ready_o), 64'd0);
    chk("bp_res1", 64'(res_o),   64'd11);
    send(2'b00, 32'd4, 32'd40);
    tick();
    chk("bp_hold", 64'(res_o),   64'd11);
    chk("bp_vhld", 64'(valid_o), 64'd1);
    tick();
    chk("bp_hld2", 64'(res_o),   64'd11);
    chk("bp_rdyh", 64'(ready_o), 64'd0);
    ready_i = 1'b1;
    #1;
    chk("bp_rdy1", 64'(ready_o), 64'd1);
    tick();
    chk("bp_res2", 64'(res_o),   64'd22);
    chk("bp_cntk", 64'(count_o), 64'd3);
    send(2'b00, 32'd5, 32'd50);
    tick();
    chk("bp_res3", 64'(res_o),   64'd33);
    idle();
    tick();
    chk("bp_res4", 64'(res_o),   64'd44);
    chk("bp_cnt2", 64'(count_o), 64'd2);
    tick();
    chk("bp_res5", 64'(res_o),   64'd55);
    tick();
    chk("bp_done", 64'(valid_o), 64'd0);
    chk("bp_cnt0", 64'(count_o), 64'd0);

    // bubble collapse
    ready_i = 1'b0;
    send(2'b11, 32'h1, 32'h2);
    tick();
    idle();
    tick();
    tick();
    chk("bc_v",    64'(valid_o), 64'd1);
    chk("bc_cnt1", 64'(count_o), 64'd1);
    send(2'b01, 32'd10, 32'd3);
    tick();
    send(2'b10, 32'hFF, 32'h3C);
    tick();
    idle();
    chk("bc_cnt3", 64'(count_o), 64'd3);
    chk("bc_rdy0", 64'(ready_o), 64'd0);
    chk("bc_res1", 64'(res_o),   64'd3);
    ready_i = 1'b1;
    tick();
    chk("bc_res2", 64'(res_o),   64'd7);
    chk("bc_v2",   64'(valid_o), 64'd1);
    tick();
    chk("bc_res3", 64'(res_o),   64'h3C);
    chk("bc_v3",   64'(valid_o), 64'd1);
    tick();
    chk("bc_done", 64'(valid_o), 64'd0);

    // flush with an input offered in the flush cycle
    ready_i = 1'b0;
    send(2'b00, 32'd1, 32'd1);
    tick();
    send(2'b00, 32'd2, 32'd2);
    tick();
    send(2'b00, 32'd3, 32'd3);
    tick();
    chk("fl_cnt3", 64'(count_o), 64'd3);
    ready_i = 1'b1;
    flush_i = 1'b1;
    send(2'b00, 32'hAA, 32'h11);
    #1;
    chk("fl_rdy0", 64'(ready_o), 64'd0);
    tick();
    flush_i = 1'b0;
    idle();
    chk("fl_v0",   64'(valid_o), 64'd0);
    chk("fl_cnt0", 64'(count_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_gone", 64'(valid_o), 64'd0);
    end
    chk("fl_cntz", 64'(count_o), 64'd0);

    // wrap / limits, 32-bit
    send(2'b00, 32'hFFFFFFFF, 32'd1);
    tick();
    send(2'b01, 32'h80000000, 32'd1);
    tick();
    idle();
    tick();
    chk("wr_v",    64'(valid_o), 64'd1);
    chk("wr_add",  64'(res_o),   64'd0);
    chk("wr_zero", 64'(zero_o),  64'd1);
    tick();
    chk("wr_sub",  64'(res_o),   64'h7FFFFFFF);
    chk("wr_neg",  64'(neg_o),   64'd0);
    chk("wr_nz",   64'(zero_o),  64'd0);
    tick();

    // 8-bit, 5-stage instance: latency 5
    vb_i = 1'b1; sb_i = 2'b00; ab_i = 8'hFF; bb_i = 8'h01;
    tick();
    vb_i = 1'b0;
    chk("b_v0", 64'(vb_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_lat", 64'(vb_o), 64'd0);
    end
    tick();
    chk("b_v5",   64'(vb_o),   64'd1);
    chk("b_add",  64'(resb_o), 64'd0);
    chk("b_zero", 64'(zb_o),   64'd1);
    vb_i = 1'b1; sb_i = 2'b01; ab_i = 8'h80; bb_i = 8'h01;
    tick();
    vb_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("b_v5s",  64'(vb_o),   64'd1);
    chk("b_sub",  64'(resb_o), 64'h7F);
    chk("b_neg",  64'(nb_o),   64'd0);
    tick();
    chk("b_done", 64'(vb_o),   64'd0);
    chk("b_cnt0", 64'(cb_o),   64'd0);

    // reset mid-stream
    ready_i = 1'b0;
    send(2'b00, 32'd4, 32'd4);
    tick();
    send(2'b00, 32'd5, 32'd5);
    tick();
    send(2'b00, 32'd6, 32'd6);
    tick();
    idle();
    chk("mr_cnt3", 64'(count_o), 64'd3);
    rst = 1'b0;
    #1;
    chk("mr_v",    64'(valid_o), 64'd0);
    chk("mr_res",  64'(res_o),   64'd0);
    chk("mr_cnt",  64'(count_o), 64'd0);
    chk("mr_rdy",  64'(ready_o), 64'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("mr_rel",  64'(ready_o), 64'd1);
    tick();
    chk("mr_vz",   64'(valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_alu.md
# pipe_alu

Parametrised, elastic successor to the fixed three-stage pipeline: an N-stage pipelined ALU with valid/ready handshakes on both sides, per-transaction operation select, bubble collapsing, back-pressure and synchronous flush. It sits in the pd-series top level between an operand producer and a result consumer. It is the datapath building block for the later execute stage.

## Interface
- DWIDTH, 32, operand/result width (≥ 2)
- STAGES, 3, pipeline depth in register stages (≥ 2); also the latency in cycles
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- valid_i  input  1  upstream transaction valid
- ready_o  output  1  block can accept a transaction this cycle
- sel_i  input  2  operation: 00 add, 01 sub (op1−op2), 10 and, 11 or
- op1_i  input  DWIDTH  operand 1
- op2_i  input  DWIDTH  operand 2
- flush_i  input  1  synchronous kill of all in-flight transactions
- valid_o  output  1  result valid
- ready_i  input  1  downstream accepts result
- res_o  output  DWIDTH  result
- zero_o  output  1  res_o == 0
- neg_o  output  1  res_o[DWIDTH-1]
- count_o  output  $clog2(STAGES+1)  number of valid stages (occupancy)

## Operation
- Stage s (0..STAGES-1) holds a valid bit v[s] and a payload.
- Stage 0 captures sel_i, op1_i and op2_i.
- Stage 1 computes the result and flags from the stage-0 payload.
- Stages 2..STAGES-1 carry the result and flags unchanged.
- Outputs come from stage STAGES-1: valid_o = v[STAGES-1]; res_o, zero_o and neg_o are that stage's payload.
- Arithmetic is modulo 2^DWIDTH; carry and borrow are discarded. neg_o is the raw MSB of the result (no overflow correction).
- Advance rule: adv[STAGES-1] = !v[STAGES-1] || ready_i. For s < STAGES-1, adv[s] = !v[s] || adv[s+1].
- A stage loads from its predecessor when adv[s] is true. Empty stages load even when downstream is stalled (bubble collapsing).
- ready_o = adv[0] && !flush_i && rst. Input transfer occurs on valid_i && ready_o.
- When a stage loads, it takes the predecessor's valid bit. If the predecessor is empty, the stage becomes empty; its payload may update but is don't-care.
- Stall: while valid_o && !ready_i, res_o, zero_o, neg_o and valid_o hold stable.
- Flush: on a clock edge with flush_i=1, every v[s] clears.
  - Flush takes priority over the input transfer and the output handshake.
  - ready_o is 0 during that cycle, so no new transaction enters.
  - A result offered in the flush cycle with ready_i=1 counts as consumed.
- count_o = popcount(v) as a registered state view. It updates on every edge: +1 on input transfer, −1 on output transfer, and reset to 0 on flush.
- Reset (rst=0, asynchronous): all v[s]=0 and all payloads=0. Therefore valid_o=0, res_o=0, zero_o=0, neg_o=0, count_o=0. ready_o=0 while rst=0.
- Reset mid-operation discards all in-flight transactions; no partial output.
- After reset deassertion, ready_o=1 in the first cycle.

## Timing
- Latency: a transaction accepted at edge k appears on valid_o after edge k+STAGES−1, i.e. STAGES cycles from the input cycle to the output cycle, absent stalls.
- Throughput: one transaction per cycle with ready_i held at 1.
- ready_o depends combinationally on ready_i through the adv chain; there is no skid buffer.
- Full condition: all v=1 and ready_i=0 gives ready_o=0. ready_i rising gives ready_o=1 in the same cycle.
- Empty condition: count_o=0 and valid_o=0.
- Simultaneous input and output transfer in a full pipe leaves count_o unchanged.
- Ordering is strictly FIFO; no transaction is dropped or duplicated except by flush or reset.

## Test plan
- Reset: assert rst=0 mid-stream with 3 transactions in flight → valid_o=0, res_o=0, count_o=0, ready_o=0 immediately. After release, ready_o=1.
- Streaming (STAGES=3, DWIDTH=32), ready_i=1: back-to-back inputs
  - add 5+7 → 12
  - sub 3−5 → 0xFFFFFFFE with neg_o=1
  - and 0xF0F0 & 0x0FF0 → 0x00F0
  - or 0 | 0 → 0 with zero_o=1
  - Required: results in order, first valid_o exactly 3 cycles after the first input cycle, then one result per cycle.
- Back-pressure: ready_i=0 while streaming 5 transactions → ready_o drops when count_o=3. res_o stays stable while stalled. Releasing ready_i delivers all 5 in order with none lost.
- Bubble collapse: one transaction, then 2 idle cycles, then ready_i=0 and 2 more inputs → count_o reaches 3 with no gaps; after release, the outputs come out on consecutive cycles.
- Flush: 3 in flight, flush_i=1 for one cycle with valid_i=1 → ready_o=0 in that cycle. Then valid_o=0 and count_o=0. The input offered in the flush cycle never appears on the output.
- Wrap/limits: add 0xFFFFFFFF+1 → res_o=0, zero_o=1. Sub 0x80000000−1 → 0x7FFFFFFF with neg_o=0. Repeat with DWIDTH=8, STAGES=5 to check that latency is 5 cycles.
